// File: rtl/ballot_pkg.sv
// Shared voting-mode definitions: FSM state encoding and default sizing, also used by the
// display/mode controller.
package ballot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAST    = 2'd2,
    ST_LOCKOUT = 2'd3
  } ballot_state_t;

  localparam int DEF_NUM_CAND       = 4;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_LOCKOUT_CYCLES = 100000000;
  localparam int DEF_ARM_TIMEOUT    = 1000000000;
  localparam int DEF_TIMER_W        = 31;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ballot_sequencer_if.sv
// Panel-side bundle of the ballot sequencer: controls and buttons in, status and tallies out.
interface ballot_sequencer_if #(
  parameter int NUM_CAND = ballot_pkg::DEF_NUM_CAND,
  parameter int CNT_W    = ballot_pkg::DEF_CNT_W
) ();
  import ballot_pkg::*;

  localparam int IDX_W = idx_width(NUM_CAND);

  logic                      mode;
  logic                      arm;
  logic [NUM_CAND-1:0]       cand_btn;
  logic                      clear_counts;
  logic                      armed;
  logic                      busy;
  logic                      valid_vote_casted;
  logic                      vote_rejected;
  logic [IDX_W-1:0]          cast_idx;
  logic [NUM_CAND*CNT_W-1:0] vote_counts;

  modport master (
    output mode, arm, cand_btn, clear_counts,
    input  armed, busy, valid_vote_casted, vote_rejected, cast_idx, vote_counts
  );

  modport slave (
    input  mode, arm, cand_btn, clear_counts,
    output armed, busy, valid_vote_casted, vote_rejected, cast_idx, vote_counts
  );

endinterface

// File: rtl/ballot_press_arbiter.sv
// Rising-edge detect on the candidate buttons, then classify the new presses as one valid
// press (with its index) or a multi-button press. Results are registered.
module ballot_press_arbiter #(
  parameter int NUM_CAND = 4,
  parameter int IDX_W    = 2
) (
  input  logic                i_clock,
  input  logic                i_rst_n,
  input  logic [NUM_CAND-1:0] i_btn,
  output logic                o_press_valid,
  output logic                o_press_multi,
  output logic [IDX_W-1:0]    o_press_idx
);

  logic [NUM_CAND-1:0] r_btn_q;
  logic [NUM_CAND-1:0] w_press;
  logic                w_multi;
  logic                w_valid;
  logic [IDX_W-1:0]    w_idx;
  logic                r_valid;
  logic                r_multi;
  logic [IDX_W-1:0]    r_idx;

  assign w_press = i_btn & ~r_btn_q;
  // clearing the lowest set bit leaves something only when two or more bits were set
  assign w_multi = (w_press & (w_press - NUM_CAND'(1))) != '0;
  assign w_valid = (w_press != '0) && !w_multi;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (w_press[i]) w_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_q <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_btn_q <= i_btn;
      r_valid <= w_valid;
      r_multi <= w_multi;
      r_idx   <= w_idx;
    end
  end

  assign o_press_valid = r_valid;
  assign o_press_multi = r_multi;
  assign o_press_idx   = r_idx;

endmodule

// File: rtl/ballot_sequencer.sv
// Voting-mode front end: one arm opens one session, one accepted press adds one vote, then lockout.
//   state   | meaning
//   IDLE    | booth closed; waits for arm rise in voting mode; tallies clearable in result mode
//   ARMED   | session open; waits for a single press, expires after ARM_TIMEOUT cycles
//   CAST    | one cycle; bumps the chosen tally (saturating) and pulses valid_vote_casted
//   LOCKOUT | booth busy for LOCKOUT_CYCLES; presses, arm and mode are ignored
module ballot_sequencer
  import ballot_pkg::*;
#(
  parameter int NUM_CAND       = DEF_NUM_CAND,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int ARM_TIMEOUT    = DEF_ARM_TIMEOUT,
  parameter int TIMER_W        = DEF_TIMER_W
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  ballot_sequencer_if.slave io_bus
);

  localparam int                 IDX_W     = idx_width(NUM_CAND);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ARM_LAST  = TIMER_W'(ARM_TIMEOUT - 1);

  ballot_state_t             r_state;
  ballot_state_t             w_state_next;
  logic [TIMER_W-1:0]        r_timer;
  logic [TIMER_W-1:0]        w_timer_next;
  logic                      r_arm_q;
  logic                      w_arm_rise;
  logic                      w_press_valid;
  logic                      w_press_multi;
  logic [IDX_W-1:0]          w_press_idx;
  logic [IDX_W-1:0]          r_sel_idx;
  logic [CNT_W-1:0]          r_tally [NUM_CAND];
  logic                      w_clear;
  logic [NUM_CAND*CNT_W-1:0] w_counts;

  logic                      w_armed;
  logic                      w_busy;
  logic                      w_valid;
  logic                      w_rejected;
  logic [IDX_W-1:0]          w_cast_idx;
  logic                      r_armed;
  logic                      r_busy;
  logic                      r_valid;
  logic                      r_rejected;
  logic [IDX_W-1:0]          r_cast_idx;
  logic [NUM_CAND*CNT_W-1:0] r_vote_counts;

  ballot_press_arbiter #(
    .NUM_CAND (NUM_CAND),
    .IDX_W    (IDX_W)
  ) u_arbiter (
    .i_clock       (i_clock),
    .i_rst_n       (i_rst_n),
    .i_btn         (io_bus.cand_btn),
    .o_press_valid (w_press_valid),
    .o_press_multi (w_press_multi),
    .o_press_idx   (w_press_idx)
  );

  assign w_arm_rise = io_bus.arm & ~r_arm_q;
  assign w_clear    = (r_state == ST_IDLE) && io_bus.mode && io_bus.clear_counts;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_arm_rise && !io_bus.mode) w_state_next = ST_ARMED;
      ST_ARMED: begin
        // a single valid press beats a timeout landing on the same cycle
        if (io_bus.mode)               w_state_next = ST_IDLE;
        else if (w_press_valid)        w_state_next = ST_CAST;
        else if (r_timer == ARM_LAST)  w_state_next = ST_IDLE;
      end
      ST_CAST:    w_state_next = ST_LOCKOUT;
      ST_LOCKOUT: if (r_timer == LOCK_LAST) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_armed    = (r_state == ST_ARMED);
    w_busy     = (r_state == ST_CAST) || (r_state == ST_LOCKOUT);
    w_valid    = (r_state == ST_CAST);
    w_rejected = (r_state == ST_ARMED) && !io_bus.mode && w_press_multi;
    w_cast_idx = (r_state == ST_CAST) ? r_sel_idx : r_cast_idx;
  end

  always_comb begin
    w_timer_next = r_timer + TIMER_W'(1);
    if ((w_state_next != r_state) || !(r_state inside {ST_ARMED, ST_LOCKOUT}))
      w_timer_next = '0;
  end

  always_comb begin
    w_counts = '0;
    for (int i = 0; i < NUM_CAND; i++) w_counts[i*CNT_W +: CNT_W] = r_tally[i];
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer   <= '0;
      r_arm_q   <= 1'b0;
      r_sel_idx <= '0;
    end else begin
      r_timer <= w_timer_next;
      r_arm_q <= io_bus.arm;
      if ((r_state == ST_ARMED) && (w_state_next == ST_CAST)) r_sel_idx <= w_press_idx;
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (w_clear)
          r_tally[i] <= '0;
        else if ((r_state == ST_CAST) && (r_sel_idx == IDX_W'(i)) && (r_tally[i] != '1))
          r_tally[i] <= r_tally[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed       <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_rejected    <= 1'b0;
      r_cast_idx    <= '0;
      r_vote_counts <= '0;
    end else begin
      r_armed       <= w_armed;
      r_busy        <= w_busy;
      r_valid       <= w_valid;
      r_rejected    <= w_rejected;
      r_cast_idx    <= w_cast_idx;
      r_vote_counts <= w_counts;
    end
  end

  assign io_bus.armed             = r_armed;
  assign io_bus.busy              = r_busy;
  assign io_bus.valid_vote_casted = r_valid;
  assign io_bus.vote_rejected     = r_rejected;
  assign io_bus.cast_idx          = r_cast_idx;
  assign io_bus.vote_counts       = r_vote_counts;

endmodule

// File: tb/tb_ballot_sequencer.sv
// Bench for ballot_sequencer: session-level reference model compared every cycle, plus
// directed scenarios with literal tally/pulse expectations.
module tb_ballot_sequencer;

  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int LOCK = 20;
  localparam int ARMT = 50;
  localparam int TW   = 8;
  localparam int TMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ballot_sequencer_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  ballot_sequencer #(
    .NUM_CAND       (NC),
    .CNT_W          (CW),
    .LOCKOUT_CYCLES (LOCK),
    .ARM_TIMEOUT    (ARMT),
    .TIMER_W        (TW)
  ) dut (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_rej    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: session phases with absolute-cycle deadlines; the outputs it
  // predicts reflect the phase held during the previous cycle.
  typedef enum {CLOSED, OPEN, CASTING, LOCKED} phase_e;
  phase_e          ph = CLOSED;
  int              cyc = 0, open_t = 0, lock_t = 0, sel = 0, np = 0;
  int              tally [NC];
  logic            prev_arm = 1'b0;
  logic [NC-1:0]   prev_btn = '0, pend = '0;
  logic            e_armed = 1'b0, e_busy = 1'b0, e_valid = 1'b0, e_rej = 1'b0;
  logic [1:0]      e_idx = '0;
  logic [NC*CW-1:0] e_counts = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = CLOSED;
      foreach (tally[i]) tally[i] = 0;
      prev_arm = 1'b0; prev_btn = '0; pend = '0;
      e_armed = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_rej = 1'b0;
      e_idx = '0; e_counts = '0; cyc = 0;
    end else begin
      np      = $countones(pend);
      e_armed = (ph == OPEN);
      e_busy  = (ph == CASTING) || (ph == LOCKED);
      e_valid = (ph == CASTING);
      e_rej   = (ph == OPEN) && !bus.mode && (np > 1);
      for (int i = 0; i < NC; i++) e_counts[i*CW +: CW] = CW'(tally[i]);
      if (ph == CASTING) e_idx = 2'(sel);
      case (ph)
        CLOSED: begin
          if (bus.arm && !prev_arm && !bus.mode) begin ph = OPEN; open_t = cyc; end
          else if (bus.mode && bus.clear_counts) foreach (tally[i]) tally[i] = 0;
        end
        OPEN: begin
          if (bus.mode) ph = CLOSED;
          else if (np == 1) begin ph = CASTING; sel = $clog2(pend); end
          else if (cyc - open_t == ARMT) ph = CLOSED;
        end
        CASTING: begin
          tally[sel] = (tally[sel] >= TMAX) ? TMAX : tally[sel] + 1;
          ph = LOCKED; lock_t = cyc;
        end
        LOCKED: if (cyc - lock_t == LOCK) ph = CLOSED;
      endcase
      pend     = bus.cand_btn & ~prev_btn;
      prev_btn = bus.cand_btn;
      prev_arm = bus.arm;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("armed", bus.armed, e_armed);
      check("busy", bus.busy, e_busy);
      check("valid_vote_casted", bus.valid_vote_casted, e_valid);
      check("vote_rejected", bus.vote_rejected, e_rej);
      check("cast_idx", bus.cast_idx, e_idx);
      check("vote_counts", bus.vote_counts, e_counts);
      if (bus.valid_vote_casted) n_valid++;
      if (bus.vote_rejected)     n_rej++;
    end
  end

  function automatic int tally_of(input int i);
    return int'(bus.vote_counts[i*CW +: CW]);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press(input logic [NC-1:0] v);
    bus.cand_btn = v; step(); bus.cand_btn = '0; step();
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1; step(); bus.arm = 1'b0; step();
  endtask

  task automatic session(input logic [NC-1:0] v);
    arm_pulse(); press(v); step(LOCK + 5);
  endtask

  int v0, r0;

  initial begin
    bus.mode = 1'b0; bus.arm = 1'b0; bus.cand_btn = '0; bus.clear_counts = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();
    check("reset_counts", bus.vote_counts, 0);
    check("reset_armed", bus.armed, 0);

    // single valid vote on candidate 2
    v0 = n_valid;
    session(4'b0100);
    check("t1_tally2", tally_of(2), 1);
    check("t1_cast_idx", bus.cast_idx, 2);
    check("t1_pulses", n_valid - v0, 1);
    check("t1_busy_done", bus.busy, 0);

    // simultaneous presses are rejected, session stays open
    r0 = n_rej;
    arm_pulse();
    bus.cand_btn = 4'b0011; step(); bus.cand_btn = '0; step(3);
    check("t2_rej_pulse", n_rej - r0, 1);
    check("t2_still_armed", bus.armed, 1);
    check("t2_tally0_unch", tally_of(0), 0);
    check("t2_tally1_unch", tally_of(1), 0);
    press(4'b0001); step(LOCK + 5);
    check("t2_tally0", tally_of(0), 1);

    // presses during lockout and while closed do nothing
    v0 = n_valid;
    arm_pulse(); press(4'b0001); step(3);
    press(4'b0010); step(LOCK);
    press(4'b0010); step(5);
    check("t3_tally1", tally_of(1), 0);
    check("t3_tally0", tally_of(0), 2);
    check("t3_pulses", n_valid - v0, 1);

    // unattended session expires
    v0 = n_valid;
    arm_pulse(); step(ARMT + 5);
    check("t4_expired", bus.armed, 0);
    press(4'b0100); step(5);
    check("t4_tally2", tally_of(2), 1);
    check("t4_pulses", n_valid - v0, 0);

    // saturation at 255
    repeat (255) session(4'b1000);
    check("t5_tally3_full", tally_of(3), 255);
    v0 = n_valid;
    session(4'b1000);
    check("t5_tally3_sat", tally_of(3), 255);
    check("t5_pulse", n_valid - v0, 1);

    // async reset mid-lockout, then clear in result mode
    arm_pulse(); press(4'b0010); step(5);
    check("t6_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_armed", bus.armed, 0);
    check("t6_rst_valid", bus.valid_vote_casted, 0);
    check("t6_rst_counts", bus.vote_counts, 0);
    check("t6_rst_idx", bus.cast_idx, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    session(4'b0001);
    session(4'b0100);
    check("t6_tally0", tally_of(0), 1);
    check("t6_tally2", tally_of(2), 1);
    bus.mode = 1'b1; bus.clear_counts = 1'b1; step();
    bus.clear_counts = 1'b0; step(2);
    check("t6_cleared", bus.vote_counts, 0);
    bus.mode = 1'b0; step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
